// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding, default bit timing and frame length helper.
package uart_pkg;

  typedef enum logic [1:0] {
    StDrain,
    StIdle,
    StWaitDone
  } arb_state_e;

  localparam int unsigned DefaultClocksPerBit = 104;

  // One 10-bit frame at (cpb+1) clocks per bit, plus two clocks of slack.
  function automatic int unsigned frame_clocks(input int unsigned cpb);
    return 10 * (cpb + 1) + 2;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first valid bit above the pointer, wrapping modulo NUM_REQ.
module uart_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdxW   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IdxW-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IdxW-1:0]    o_grantIdx,
  output logic               o_any
);

  always_comb begin
    logic            found;
    logic [IdxW-1:0] cand;
    found      = 1'b0;
    cand       = '0;
    o_grant    = '0;
    o_grantIdx = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IdxW'((32'(i_ptr) + i) % NUM_REQ);
      if (!found && i_valid[cand]) begin
        found         = 1'b1;
        o_grant[cand] = 1'b1;
        o_grantIdx    = cand;
      end
    end
    o_any = found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin byte scheduler in front of a single uart_tx.
// Optional burst locking via `define UART_TX_ARBITER_LOCK_EN (adds i_reqLast).
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned CLOCKS_PER_BIT = DefaultClocksPerBit,
  parameter int unsigned DRAIN_CLOCKS   = frame_clocks(CLOCKS_PER_BIT)
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic [NUM_REQ-1:0]         i_reqValid,
  input  logic [8*NUM_REQ-1:0]       i_reqData,
`ifdef UART_TX_ARBITER_LOCK_EN
  input  logic [NUM_REQ-1:0]         i_reqLast,
`endif
  output logic [NUM_REQ-1:0]         o_reqReady,
  output logic [$clog2(NUM_REQ)-1:0] o_grantId,
  output logic                       o_busy,
  output logic                       o_txBegin,
  output logic [7:0]                 o_txData,
  input  logic                       i_txDone
);

  localparam int unsigned IdxW      = $clog2(NUM_REQ);
  localparam logic [31:0] DrainLast = 32'(DRAIN_CLOCKS - 1);

  arb_state_e         state_q;
  logic [15:0]        drain_cnt_q;
  logic [IdxW-1:0]    ptr_q;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] win_onehot;
  logic [IdxW-1:0]    win_idx;
  logic               win_any;
  logic [7:0]         win_data;
  logic               drain_done;

`ifdef UART_TX_ARBITER_LOCK_EN
  logic               lock_q;
  logic [NUM_REQ-1:0] lock_mask;

  always_comb begin
    lock_mask            = '0;
    lock_mask[o_grantId] = 1'b1;
  end

  // While locked, only the requester of the last accepted byte may win.
  assign eligible = lock_q ? (i_reqValid & lock_mask) : i_reqValid;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      lock_q <= 1'b0;
    end else if (state_q == StIdle && win_any) begin
      lock_q <= ~i_reqLast[win_idx];
    end
  end
`else
  assign eligible = i_reqValid;
`endif

  uart_rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .i_valid   (eligible),
    .i_ptr     (ptr_q),
    .o_grant   (win_onehot),
    .o_grantIdx(win_idx),
    .o_any     (win_any)
  );

  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_onehot[i]) win_data = i_reqData[8*i +: 8];
    end
  end

  // Counter saturates, so an oversized DRAIN_CLOCKS still ends the drain.
  assign drain_done = ({16'd0, drain_cnt_q} >= DrainLast) || (&drain_cnt_q);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= StDrain;
      drain_cnt_q <= '0;
      ptr_q       <= IdxW'(NUM_REQ - 1);
      o_reqReady  <= '0;
      o_grantId   <= '0;
      o_busy      <= 1'b0;
      o_txBegin   <= 1'b0;
      o_txData    <= '0;
    end else begin
      o_txBegin  <= 1'b0;
      o_reqReady <= '0;
      unique case (state_q)
        StDrain: begin
          if (!(&drain_cnt_q)) drain_cnt_q <= drain_cnt_q + 16'd1;
          if (i_txDone || drain_done) begin
            state_q <= StIdle;
            o_busy  <= 1'b0;
          end else begin
            o_busy  <= 1'b1;
          end
        end
        StIdle: begin
          if (win_any) begin
            state_q    <= StWaitDone;
            o_busy     <= 1'b1;
            o_txBegin  <= 1'b1;
            o_reqReady <= win_onehot;
            o_txData   <= win_data;
            o_grantId  <= win_idx;
            ptr_q      <= win_idx;
          end
        end
        StWaitDone: begin
          if (i_txDone) begin
            state_q <= StIdle;
            o_busy  <= 1'b0;
          end
        end
        default: begin
          state_q <= StDrain;
          o_busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; the transmitter's done pulse is driven by hand.
module tb_uart_tx_arbiter;

  localparam int unsigned NumReq = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NumReq-1:0] req_valid;
  logic [8*NumReq-1:0] req_data;
  logic [NumReq-1:0] req_ready;
  logic [1:0]        grant_id;
  logic              busy;
  logic              tx_begin;
  logic [7:0]        tx_data;
  logic              tx_done;
`ifdef UART_TX_ARBITER_LOCK_EN
  logic [NumReq-1:0] req_last;
`endif

  int tests = 0;
  int fails = 0;
  int early;
  logic [3:0] exp_rdy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(NumReq)
  ) dut (
    .i_clock   (clk),
    .i_reset   (rst),
    .i_reqValid(req_valid),
    .i_reqData (req_data),
`ifdef UART_TX_ARBITER_LOCK_EN
    .i_reqLast (req_last),
`endif
    .o_reqReady(req_ready),
    .o_grantId (grant_id),
    .o_busy    (busy),
    .o_txBegin (tx_begin),
    .o_txData  (tx_data),
    .i_txDone  (tx_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  task automatic chk_grant(input string tag, input int g, input logic [7:0] d);
    exp_rdy = 4'b0001 << g;
    chk({tag, "_begin"}, 32'(tx_begin), 32'd1);
    chk({tag, "_gid"}, 32'(grant_id), 32'(g));
    chk({tag, "_data"}, 32'(tx_data), 32'(d));
    chk({tag, "_ready"}, 32'(req_ready), 32'(exp_rdy));
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    tx_done   = 1'b0;
`ifdef UART_TX_ARBITER_LOCK_EN
    req_last  = '1;
`endif

    // Reset state
    step();
    chk("rst_begin", 32'(tx_begin), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Post-reset drain: no begin through cycle 1052, begin at 1053
    rst            = 1'b0;
    req_valid      = 4'b0001;
    req_data[7:0]  = 8'h55;
    early          = 0;
    for (int c = 1; c <= 1052; c++) begin
      step();
      if (tx_begin) early++;
      if (c == 1) chk("drain_busy", 32'(busy), 32'd1);
    end
    chk("drain_no_early_begin", 32'(early), 32'd0);
    chk("drain_idle_busy", 32'(busy), 32'd0);
    step();
    chk_grant("drain_first", 0, 8'h55);
    chk("drain_first_busy", 32'(busy), 32'd1);
    req_valid = '0;
    step();
    chk("pulse_begin_once", 32'(tx_begin), 32'd0);
    chk("pulse_ready_once", 32'(req_ready), 32'd0);
    pulse_done();
    chk("done_to_idle_busy", 32'(busy), 32'd0);

    // Single source: begin exactly two cycles after each done
    req_valid       = 4'b1000;
    req_data[31:24] = 8'h3C;
    step();
    chk_grant("single0", 3, 8'h3C);
    for (int k = 0; k < 3; k++) begin
      step();
      pulse_done();
      chk("single_gap_t1", 32'(tx_begin), 32'd0);
      step();
      chk_grant("single_t2", 3, 8'h3C);
    end
    step();
    pulse_done();

    // Fairness: all valid, expect 0,1,2,3,0,1,2,3
    req_valid = 4'b1111;
    req_data  = 32'h1312_1110;
    for (int k = 0; k < 8; k++) begin
      if (k != 0) begin
        pulse_done();
        chk("fair_idle_begin", 32'(tx_begin), 32'd0);
      end
      step();
      chk_grant("fair", k % 4, 8'(8'h10 + k % 4));
      step();
      chk("fair_ready_1cyc", 32'(req_ready), 32'd0);
      chk("fair_wait_data", 32'(tx_data), 32'(8'h10 + k % 4));
    end

    // Reset mid-frame, then early drain exit on done at cycle 20
    req_valid = 4'b0100;
    req_data  = 32'h00A3_0000;
    rst       = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_begin", 32'(tx_begin), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd0);
    chk("midrst_gid", 32'(grant_id), 32'd0);
    chk("midrst_data", 32'(tx_data), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    early = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (tx_begin) early++;
      if (c == 1) chk("midrst_drain_busy", 32'(busy), 32'd1);
    end
    chk("midrst_no_begin", 32'(early), 32'd0);
    pulse_done();
    chk("early_exit_idle_busy", 32'(busy), 32'd0);
    chk("early_exit_no_begin_yet", 32'(tx_begin), 32'd0);
    step();
    chk_grant("early_exit", 2, 8'hA3);

    // Reset and done together: reset wins, arbiter stays in DRAIN
    rst     = 1'b1;
    tx_done = 1'b1;
    step();
    rst     = 1'b0;
    tx_done = 1'b0;
    chk("rstdone_busy0", 32'(busy), 32'd0);
    step();
    chk("rstdone_drain_busy", 32'(busy), 32'd1);
    chk("rstdone_no_begin1", 32'(tx_begin), 32'd0);
    step();
    chk("rstdone_no_begin2", 32'(tx_begin), 32'd0);

`ifdef UART_TX_ARBITER_LOCK_EN
    // Lock: req1 burst of three bytes holds off req0
    req_valid      = 4'b0010;
    req_data       = 32'h0000_4100;
    req_last       = 4'b0000;
    pulse_done();
    step();
    chk_grant("lock_b0", 1, 8'h41);
    req_valid = 4'b0011;
    req_data  = 32'h0000_4201;
    step();
    pulse_done();
    step();
    chk_grant("lock_b1", 1, 8'h42);
    req_data = 32'h0000_4301;
    req_last = 4'b0010;
    step();
    pulse_done();
    step();
    chk_grant("lock_b2", 1, 8'h43);
    step();
    pulse_done();
    step();
    chk_grant("lock_release", 0, 8'h01);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler sharing one `uart_tx` transmitter among `NUM_REQ` byte sources. It accepts one byte at a time from the granted requester and pulses `o_txBegin` with the byte. It then waits for the transmitter's `i_txDone` pulse before arbitrating again. It sits between the LCD/debug byte producers and the single serial output.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `CLOCKS_PER_BIT`, 104: must equal the `uart_tx` setting.
- `DRAIN_CLOCKS`, `10*(CLOCKS_PER_BIT+1)+2`: post-reset wait, at least one full frame.

Ports:
- `i_clock`, in, 1: sole clock.
- `i_reset`, in, 1: synchronous, active-high reset.
- `i_reqValid`, in, `NUM_REQ`: requester n has a byte; held until its ready pulse.
- `i_reqData`, in, `8*NUM_REQ`: byte n in bits `[8n+7:8n]`; stable while valid.
- `o_reqReady`, out, `NUM_REQ`: one-cycle accept pulse, one-hot.
- `o_grantId`, out, `$clog2(NUM_REQ)`: requester of the byte in flight.
- `o_busy`, out, 1: high in every state except IDLE.
- `o_txBegin`, out, 1: one-cycle start pulse to `uart_tx`.
- `o_txData`, out, 8: byte to `uart_tx`, valid with `o_txBegin`.
- `i_txDone`, in, 1: one-cycle frame-complete pulse from `uart_tx`.

## Operation
- **States:** DRAIN, IDLE, WAIT_DONE.
- **Reset:**
  - All outputs go to 0.
  - State goes to DRAIN; drain counter goes to 0.
  - Round-robin pointer goes to `NUM_REQ-1`, so requester 0 wins first.
- **DRAIN:**
  - Purpose: the transmitter has no reset and may be mid-frame.
  - Exit to IDLE on `i_txDone`=1, or when the counter reaches `DRAIN_CLOCKS-1`.
  - No begin or ready pulses are issued in DRAIN.
- **IDLE:**
  - The winner is the first asserted `i_reqValid` bit, searching upward from pointer+1 and wrapping modulo `NUM_REQ`.
  - If any request is valid, at the next edge:
    - `o_txBegin`=1 and `o_reqReady[winner]`=1 for exactly one cycle;
    - `o_txData` and `o_grantId` are loaded;
    - pointer becomes the winner;
    - state goes to WAIT_DONE.
  - If no request is valid, stay in IDLE.
- **WAIT_DONE:**
  - On `i_txDone`=1, go to IDLE.
  - Otherwise hold. Valid requests are ignored, and `o_txData`/`o_grantId` stay stable.
- **Request handling:**
  - A valid request dropped before its ready pulse is lost from arbitration; this is legal.
  - Requests already valid keep their round-robin order.
- **Start-pulse constraint:** `o_txBegin` is never asserted outside the IDLE→WAIT_DONE transition, and never twice per frame.

## Timing
- Valid seen in IDLE at cycle t → `o_txBegin`/`o_reqReady` high at cycle t+1.
- `i_txDone` at cycle t → IDLE at t+1 → next `o_txBegin` no earlier than t+2. `uart_tx` is back in its idle state by then.
- Back-to-back gap between frames is 2 clocks after done.
- **Reset mid-frame:** outputs clear at the next edge and DRAIN starts. The first new begin occurs no earlier than the first `i_txDone` or `DRAIN_CLOCKS` cycles.
- **Simultaneous `i_reset` and `i_txDone`:** reset wins; state is DRAIN.
- **Drain counter:** 16 bits; saturates and never wraps.

## Configuration
- **`UART_TX_ARBITER_LOCK_EN` defined:**
  - Adds port `i_reqLast`, in, `NUM_REQ`, qualified with valid.
  - After a byte accepted with last=0, arbitration in IDLE considers only the granted requester; the pointer does not move.
  - Accepting a byte with last=1 releases the lock.
  - A locked requester with valid low stalls the arbiter in IDLE until it returns or reset.
- **Undefined:** no `i_reqLast` port; arbitration is per byte.

## Structure
- Shared `uart_pkg` holds:
  - state enum `{DRAIN, IDLE, WAIT_DONE}`;
  - `CLOCKS_PER_BIT` default;
  - frame-length function `10*(cpb+1)+2`.
- Sub-module `uart_rr_pick`: purely combinational. Takes the valid vector and pointer; returns the one-hot winner and index. It is reusable by other shared-resource arbiters.

## Test plan
- **Post-reset drain:** reset, then req0 valid with 0x55, no done → no `o_txBegin` before cycle 1052; begin with 0x55 at cycle 1053.
- **Early drain exit:** `i_txDone` pulse at cycle 20 during DRAIN with req2=0xA3 valid → begin two cycles later with `o_grantId`=2.
- **Fairness:** all four requesters always valid (0x10..0x13), 8 frames → grant order 0,1,2,3,0,1,2,3; each ready pulse is one cycle and one-hot.
- **Single source:** only req3 valid → consecutive grants to 3, begin exactly 2 cycles after each done.
- **Reset mid-frame:** reset during WAIT_DONE → all outputs 0 the next cycle; DRAIN re-entered; no begin until done or timeout.
- **Lock (`LOCK_EN` defined):** req1 sends 3 bytes with last=0,0,1 while req0 is valid → req0 is granted only after req1's last byte.
